// File: rtl/msu_sd_sector_responder.sv
// Sector-read responder for the MSU audio path: accepts sd_rd requests and
// streams one sector of image words, zero-filling past the image end.
module msu_sd_sector_responder #(
    parameter int WORDS_PER_SECTOR = 256,
    parameter int ACK_DELAY        = 4,
    parameter int WR_GAP           = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_rd,
    input  logic [20:0] sd_lba,
    input  logic [63:0] img_size,
    output logic        sd_ack,
    output logic [7:0]  sd_buff_addr,
    output logic [15:0] sd_buff_dout,
    output logic        sd_buff_wr,
    output logic        mem_rd,
    output logic [28:0] mem_addr,
    input  logic [15:0] mem_q,
    output logic        busy,
    output logic        out_of_range,
    output logic [15:0] sector_count
);

    typedef enum logic [1:0] {IDLE, ACK_WAIT, XFER, DONE} state_t;

    localparam logic [7:0] LAST     = 8'(WORDS_PER_SECTOR - 1);
    localparam logic [7:0] DLY_LAST = 8'(ACK_DELAY - 1);
    localparam logic [3:0] GAP      = 4'(WR_GAP);

    localparam logic [1:0] M_FULL = 2'd0;
    localparam logic [1:0] M_HALF = 2'd1;
    localparam logic [1:0] M_ZERO = 2'd2;

    state_t      state;
    logic [20:0] lba;
    logic [63:0] size;
    logic [7:0]  dly;
    logic [3:0]  gap;
    logic [7:0]  rd_idx;
    logic        rd_done;

    logic        p1_v, p2_v;
    logic [7:0]  p1_idx, p2_idx;
    logic [1:0]  p1_mode, p2_mode;

    logic        issue;
    logic [63:0] byte_addr;
    logic [63:0] acc_base;
    logic [1:0]  mode;

    // Read-slot scheduling and fill-mode classification of the next word
    always_comb begin
        issue     = 1'b0;
        byte_addr = {34'd0, lba, rd_idx, 1'b0};
        acc_base  = {34'd0, sd_lba, 9'd0};
        mode      = M_FULL;
        if (state == ACK_WAIT && dly == DLY_LAST)
            issue = 1'b1;
        if (state == XFER && !rd_done && gap == 4'd0)
            issue = 1'b1;
        if (byte_addr >= size)
            mode = M_ZERO;
        else if (byte_addr + 64'd1 == size)
            mode = M_HALF;
    end

    // Control FSM, read issue, two-stage data pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lba          <= '0;
            size         <= '0;
            dly          <= '0;
            gap          <= '0;
            rd_idx       <= '0;
            rd_done      <= 1'b0;
            p1_v         <= 1'b0;
            p2_v         <= 1'b0;
            p1_idx       <= '0;
            p2_idx       <= '0;
            p1_mode      <= M_FULL;
            p2_mode      <= M_FULL;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
            out_of_range <= 1'b0;
            sector_count <= '0;
        end else begin
            out_of_range <= 1'b0;
            mem_rd       <= 1'b0;
            p1_v         <= 1'b0;
            p2_v         <= p1_v;
            p2_idx       <= p1_idx;
            p2_mode      <= p1_mode;
            sd_buff_wr   <= p2_v;

            if (p2_v) begin
                sd_buff_addr <= p2_idx;
                unique case (p2_mode)
                    M_FULL:  sd_buff_dout <= mem_q;
                    M_HALF:  sd_buff_dout <= {8'h00, mem_q[7:0]};
                    default: sd_buff_dout <= 16'h0000;
                endcase
            end

            if (issue) begin
                p1_v     <= 1'b1;
                p1_idx   <= rd_idx;
                p1_mode  <= mode;
                mem_rd   <= (mode != M_ZERO);
                mem_addr <= {lba, rd_idx};
                gap      <= GAP;
                if (rd_idx == LAST)
                    rd_done <= 1'b1;
                else
                    rd_idx <= rd_idx + 8'd1;
            end else if (gap != 4'd0) begin
                gap <= gap - 4'd1;
            end

            unique case (state)
                IDLE: begin
                    if (sd_rd) begin
                        lba          <= sd_lba;
                        size         <= img_size;
                        dly          <= '0;
                        rd_idx       <= '0;
                        rd_done      <= 1'b0;
                        out_of_range <= (acc_base >= img_size);
                        busy         <= 1'b1;
                        state        <= ACK_WAIT;
                    end
                end
                ACK_WAIT: begin
                    if (dly == DLY_LAST) begin
                        sd_ack <= 1'b1;
                        state  <= XFER;
                    end else begin
                        dly <= dly + 8'd1;
                    end
                end
                XFER: begin
                    if (sd_buff_wr && sd_buff_addr == LAST) begin
                        sd_ack       <= 1'b0;
                        sector_count <= sector_count + 16'd1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msu_sd_sector_responder.sv
// Scoreboard bench for msu_sd_sector_responder: directed sector requests,
// expected words queued at issue, compared by a negedge monitor.
module tb_msu_sd_sector_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd_rd = 1'b0;
    logic [20:0] sd_lba = '0;
    logic [63:0] img_size = '0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic        mem_rd;
    logic [28:0] mem_addr;
    logic [15:0] mem_q = '0;
    logic        busy;
    logic        out_of_range;
    logic [15:0] sector_count;

    logic        g_rd = 1'b0;
    logic        g_ack, g_wr, g_mem_rd, g_busy, g_oor;
    logic [7:0]  g_addr;
    logic [15:0] g_dout, g_mem_q = '0, g_cnt;
    logic [28:0] g_mem_addr;

    logic [15:0] mem [0:2047];

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int ack_rise, ack_fall, busy_fall, first_wr, last_wr;
    int wr_n, rd_n, oor_n, g_n, g_prev;
    logic [28:0] rd_lo, rd_hi;
    logic [7:0]  first_addr;
    logic [15:0] first_data, w18_data;
    logic        prev_ack = 1'b0, prev_busy = 1'b0;

    msu_sd_sector_responder dut (
        .clk(clk), .reset(reset), .sd_rd(sd_rd), .sd_lba(sd_lba),
        .img_size(img_size), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q), .busy(busy),
        .out_of_range(out_of_range), .sector_count(sector_count)
    );

    msu_sd_sector_responder #(.WR_GAP(2)) dut_g (
        .clk(clk), .reset(reset), .sd_rd(g_rd), .sd_lba(21'd0),
        .img_size(64'd1060), .sd_ack(g_ack), .sd_buff_addr(g_addr),
        .sd_buff_dout(g_dout), .sd_buff_wr(g_wr),
        .mem_rd(g_mem_rd), .mem_addr(g_mem_addr), .mem_q(g_mem_q),
        .busy(g_busy), .out_of_range(g_oor), .sector_count(g_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_q <= mem[mem_addr[10:0]];
        if (g_mem_rd) g_mem_q <= mem[g_mem_addr[10:0]];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe, gathers timing
    always @(negedge clk) begin
        int rel;
        wr_t e;
        if (!reset) begin
            rel = cyc - t0;
            if (sd_ack && !prev_ack) ack_rise = rel;
            if (!sd_ack && prev_ack) ack_fall = rel;
            if (!busy && prev_busy) busy_fall = rel;
            if (sd_buff_wr) begin
                if (wr_n == 0) begin
                    first_wr   = rel;
                    first_addr = sd_buff_addr;
                    first_data = sd_buff_dout;
                end
                if (sd_buff_addr == 8'd18) w18_data = sd_buff_dout;
                last_wr = rel;
                wr_n++;
                if (!sd_ack) chk("wr_without_ack", 1, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", {56'd0, sd_buff_addr}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {56'd0, sd_buff_addr}, {56'd0, e.addr});
                    chk("wr_data", {48'd0, sd_buff_dout}, {48'd0, e.data});
                end
            end
            if (mem_rd) begin
                if (rd_n == 0) rd_lo = mem_addr;
                rd_hi = mem_addr;
                rd_n++;
            end
            if (out_of_range) oor_n++;
            if (g_wr) begin
                if (g_n > 0) chk("gap", 64'(cyc - g_prev), 64'd3);
                chk("g_data", {48'd0, g_dout}, {56'd0, g_addr});
                g_prev = cyc;
                g_n++;
            end
        end
        prev_ack  = sd_ack;
        prev_busy = busy;
    end

    task automatic clear_stats();
        ack_rise = -1; ack_fall = -1; busy_fall = -1;
        first_wr = -1; last_wr = -1;
        wr_n = 0; rd_n = 0; oor_n = 0;
        rd_lo = '0; rd_hi = '0; w18_data = '0;
    endtask

    task automatic push_sector(input int lba, input longint size);
        wr_t e;
        longint b;
        for (int w = 0; w < 256; w++) begin
            b = longint'(lba) * 512 + 2 * w;
            e.addr = 8'(w);
            if (b + 1 < size)
                e.data = mem[11'(lba * 256 + w)];
            else if (b + 1 == size)
                e.data = {8'h00, mem[11'(lba * 256 + w)][7:0]};
            else
                e.data = 16'h0000;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_sig(input string name, input int which,
                            input logic lvl);
        logic v;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            v = (which == 0) ? sd_ack : (which == 1) ? busy :
                (which == 2) ? g_ack : g_busy;
            if (v == lvl) return;
        end
        chk({"timeout_", name}, 0, 1);
    endtask

    task automatic run_req(input int lba, input longint size);
        @(negedge clk);
        clear_stats();
        push_sector(lba, size);
        sd_lba   = 21'(lba);
        img_size = 64'(size);
        sd_rd    = 1'b1;
        t0       = cyc;
        wait_sig("ack", 0, 1'b1);
        sd_rd = 1'b0;
        wait_sig("busy", 1, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int n = 0; n < 2048; n++) mem[n] = 16'(n);
        mem[530] = 16'hABCD;
        clear_stats();
        g_n = 0;
        g_prev = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {63'd0, sd_ack}, 0);
        chk("rst_addr", {56'd0, sd_buff_addr}, 0);
        chk("rst_dout", {48'd0, sd_buff_dout}, 0);
        chk("rst_wr", {63'd0, sd_buff_wr}, 0);
        chk("rst_mem_rd", {63'd0, mem_rd}, 0);
        chk("rst_mem_addr", {35'd0, mem_addr}, 0);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_oor", {63'd0, out_of_range}, 0);
        chk("rst_count", {48'd0, sector_count}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy", {63'd0, busy}, 0);
        end

        // Full sector, default timing
        run_req(0, 1060);
        chk("full_ack_rise", 64'(ack_rise), 5);
        chk("full_first_wr", 64'(first_wr), 7);
        chk("full_last_wr", 64'(last_wr), 262);
        chk("full_ack_fall", 64'(ack_fall), 263);
        chk("full_busy_fall", 64'(busy_fall), 264);
        chk("full_wr_n", 64'(wr_n), 256);
        chk("full_rd_n", 64'(rd_n), 256);
        chk("full_count", {48'd0, sector_count}, 1);
        chk("full_q_empty", 64'(exp_q.size()), 0);

        // Partial tail
        run_req(2, 1060);
        chk("tail_rd_n", 64'(rd_n), 18);
        chk("tail_rd_lo", {35'd0, rd_lo}, 512);
        chk("tail_rd_hi", {35'd0, rd_hi}, 529);
        chk("tail_oor", 64'(oor_n), 0);
        chk("tail_wr_n", 64'(wr_n), 256);
        chk("tail_count", {48'd0, sector_count}, 2);

        // Odd image size: last byte half-filled
        run_req(2, 1061);
        chk("odd_w18", {48'd0, w18_data}, 64'h00CD);
        chk("odd_rd_n", 64'(rd_n), 19);
        chk("odd_oor", 64'(oor_n), 0);

        // Sector entirely past the image end
        run_req(3, 1061);
        chk("oor_pulses", 64'(oor_n), 1);
        chk("oor_rd_n", 64'(rd_n), 0);
        chk("oor_wr_n", 64'(wr_n), 256);
        chk("oor_count", {48'd0, sector_count}, 4);

        // Back-to-back with sd_rd held high
        @(negedge clk);
        clear_stats();
        push_sector(0, 1060);
        push_sector(1, 1060);
        sd_lba   = 21'd0;
        img_size = 64'd1060;
        sd_rd    = 1'b1;
        t0       = cyc;
        wait_sig("b2b_ack1", 0, 1'b1);
        sd_lba = 21'd1;
        wait_sig("b2b_fall1", 0, 1'b0);
        wait_sig("b2b_ack2", 0, 1'b1);
        sd_rd = 1'b0;
        chk("b2b_ack2_at", 64'(cyc - t0), 269);
        wait_sig("b2b_busy", 1, 1'b0);
        repeat (2) @(negedge clk);
        chk("b2b_wr_n", 64'(wr_n), 512);
        chk("b2b_count", {48'd0, sector_count}, 6);
        chk("b2b_q_empty", 64'(exp_q.size()), 0);

        // Write gap of two idle cycles
        @(negedge clk);
        g_rd = 1'b1;
        wait_sig("g_ack", 2, 1'b1);
        g_rd = 1'b0;
        wait_sig("g_busy", 3, 1'b0);
        chk("g_wr_n", 64'(g_n), 256);
        chk("g_count", {48'd0, g_cnt}, 1);

        // Reset in the middle of a stream
        @(negedge clk);
        clear_stats();
        push_sector(0, 1060);
        sd_lba   = 21'd0;
        img_size = 64'd1060;
        sd_rd    = 1'b1;
        t0       = cyc;
        wait_sig("mid_ack", 0, 1'b1);
        sd_rd = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 400 && !hit; i++) begin
                @(negedge clk);
                if (sd_buff_wr && sd_buff_addr == 8'd100) hit = 1;
            end
            if (!hit) chk("timeout_word100", 0, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("mid_ack", {63'd0, sd_ack}, 0);
        chk("mid_wr", {63'd0, sd_buff_wr}, 0);
        chk("mid_count", {48'd0, sector_count}, 0);
        chk("mid_busy", {63'd0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        run_req(0, 1060);
        chk("post_first_addr", {56'd0, first_addr}, 0);
        chk("post_first_data", {48'd0, first_data}, 0);
        chk("post_wr_n", 64'(wr_n), 256);
        chk("post_ack_rise", 64'(ack_rise), 5);
        chk("post_count", {48'd0, sector_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
